// File: rtl/lna_seq_pkg.sv
// lna_seq_pkg: shared state encoding, fault codes and duty width for the LNA power sequencer.
package lna_seq_pkg;
  typedef enum logic [3:0] {
    S_OFF        = 4'd0,
    S_NEG_WAIT   = 4'd1,
    S_NEG_SETTLE = 4'd2,
    S_POS_RAMP   = 4'd3,
    S_POS_WAIT   = 4'd4,
    S_ON         = 4'd5,
    S_POS_DOWN   = 4'd6,
    S_NEG_DOWN   = 4'd7,
    S_FAULT      = 4'd8
  } state_t;
  localparam logic [1:0] FC_NONE        = 2'd0;
  localparam logic [1:0] FC_NEG_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_POS         = 2'd2;
  localparam logic [1:0] FC_NEG_LOST    = 2'd3;
  localparam int DUTY_W = 9;
  localparam logic [DUTY_W-1:0] DUTY_FULL = 9'd256;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/lna_softstart_pwm.sv
// lna_softstart_pwm: 8-bit PWM with a prescaled up/down duty ramp for the Vplus soft start/stop.
module lna_softstart_pwm
  import lna_seq_pkg::*;
#(
  parameter int STEP_CYC = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic up,
  input  logic down,
  input  logic clr,
  output logic pwm,
  output logic at_full,
  output logic at_zero
);
  localparam int PW = $clog2(STEP_CYC) > 0 ? $clog2(STEP_CYC) : 1;
  logic [7:0] cnt;
  logic [PW-1:0] pre;
  logic [DUTY_W-1:0] duty;
  logic step;
  assign step = (up || down) && pre == PW'(STEP_CYC - 1);
  assign at_full = duty == DUTY_FULL;
  assign at_zero = duty == '0;
  // duty is 9 bits so 256 keeps the output high on every counter value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      pre  <= '0;
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      cnt  <= cnt + 8'd1;
      pre  <= (clr || !(up || down) || step) ? '0 : pre + 1'b1;
      duty <= clr ? '0 :
              (step && up && !at_full) ? duty + 1'b1 :
              (step && down && !at_zero) ? duty - 1'b1 : duty;
      pwm  <= !clr && ({1'b0, cnt} < duty);
    end
  end
endmodule

// File: rtl/lna_power_sequencer.sv
// lna_power_sequencer: orders LNA gate/drain bias rails, supervises power-good and latches faults.
module lna_power_sequencer
  import lna_seq_pkg::*;
#(
  parameter int RAMP_STEP_CYC   = 100,
  parameter int NEG_TIMEOUT_CYC = 100000,
  parameter int NEG_SETTLE_CYC  = 10000,
  parameter int POS_TIMEOUT_CYC = 100000,
  parameter int NEG_HOLD_CYC    = 10000
) (
  input  logic       Clock100Mhz,
  input  logic       ResetN,
  input  logic       PowerRequest,
  input  logic       VminusGood,
  input  logic       VplusGood,
  input  logic       FaultClear,
  output logic       VminusEnable,
  output logic       VplusPwm,
  output logic       LnaReady,
  output logic       Fault,
  output logic [1:0] FaultCode,
  output logic [2:0] State
);
  localparam int TMAX = max2(max2(NEG_TIMEOUT_CYC, POS_TIMEOUT_CYC), max2(NEG_SETTLE_CYC, NEG_HOLD_CYC));
  localparam int TW = $clog2(TMAX + 1);
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [1:0] vm_sync, vp_sync, code_n;
  logic vm, vp, at_full, at_zero, ven_n;
  logic neg_to, pos_to, settle_done, hold_done;
  assign vm = vm_sync[1];
  assign vp = vp_sync[1];
  assign State = state[2:0];
  assign neg_to = timer >= TW'(NEG_TIMEOUT_CYC - 1);
  assign pos_to = timer >= TW'(POS_TIMEOUT_CYC - 1);
  assign settle_done = timer >= TW'(NEG_SETTLE_CYC - 1);
  assign hold_done = timer >= TW'(NEG_HOLD_CYC - 1);
  // one shared timer, restarted on every state change and saturating so FAULT hold stays expired
  assign timer_n = (state_n != state) ? '0 : (timer == TW'(TMAX)) ? timer : timer + 1'b1;
  assign ven_n = (state_n == S_FAULT) ? timer_n < TW'(NEG_HOLD_CYC) : state_n != S_OFF;
  lna_softstart_pwm #(.STEP_CYC(RAMP_STEP_CYC)) u_pwm (
    .clk     (Clock100Mhz),
    .rst_n   (ResetN),
    .up      (state == S_POS_RAMP),
    .down    (state == S_POS_DOWN),
    .clr     (state_n == S_FAULT),
    .pwm     (VplusPwm),
    .at_full (at_full),
    .at_zero (at_zero)
  );
  // Vminus loss outranks Vplus loss, which outranks a dropped request
  always_comb begin
    state_n = state;
    code_n  = FaultCode;
    case (state)
      S_OFF: state_n = PowerRequest ? S_NEG_WAIT : S_OFF;
      S_NEG_WAIT:
        if (vm) state_n = S_NEG_SETTLE;
        else if (neg_to) begin state_n = S_FAULT; code_n = FC_NEG_TIMEOUT; end
        else if (!PowerRequest) state_n = S_NEG_DOWN;
      S_NEG_SETTLE:
        if (!vm) begin state_n = S_FAULT; code_n = FC_NEG_LOST; end
        else if (!PowerRequest) state_n = S_NEG_DOWN;
        else if (settle_done) state_n = S_POS_RAMP;
      S_POS_RAMP:
        if (!vm) begin state_n = S_FAULT; code_n = FC_NEG_LOST; end
        else if (!PowerRequest) state_n = S_POS_DOWN;
        else if (at_full) state_n = S_POS_WAIT;
      S_POS_WAIT:
        if (!vm) begin state_n = S_FAULT; code_n = FC_NEG_LOST; end
        else if (!PowerRequest) state_n = S_POS_DOWN;
        else if (vp) state_n = S_ON;
        else if (pos_to) begin state_n = S_FAULT; code_n = FC_POS; end
      S_ON:
        if (!vm) begin state_n = S_FAULT; code_n = FC_NEG_LOST; end
        else if (!vp) begin state_n = S_FAULT; code_n = FC_POS; end
        else if (!PowerRequest) state_n = S_POS_DOWN;
      S_POS_DOWN: state_n = at_zero ? S_NEG_DOWN : S_POS_DOWN;
      S_NEG_DOWN: state_n = hold_done ? S_OFF : S_NEG_DOWN;
      S_FAULT:
        if (FaultClear && !PowerRequest && hold_done) begin state_n = S_OFF; code_n = FC_NONE; end
      default: state_n = S_OFF;
    endcase
  end
  always_ff @(posedge Clock100Mhz) begin
    if (!ResetN) begin
      state        <= S_OFF;
      timer        <= '0;
      vm_sync      <= '0;
      vp_sync      <= '0;
      VminusEnable <= 1'b0;
      LnaReady     <= 1'b0;
      Fault        <= 1'b0;
      FaultCode    <= FC_NONE;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      vm_sync      <= {vm_sync[0], VminusGood};
      vp_sync      <= {vp_sync[0], VplusGood};
      VminusEnable <= ven_n;
      LnaReady     <= state_n == S_ON;
      Fault        <= state_n == S_FAULT;
      FaultCode    <= code_n;
    end
  end
endmodule

// File: tb/tb_lna_power_sequencer.sv
// tb_lna_power_sequencer: table-driven directed checks plus hand-written ramp-abort and reset sequences.
module tb_lna_power_sequencer;
  typedef struct {
    string nm;
    bit req, vm, vp, fclr;
    int cyc, st, flt, code, ven, rdy, pwm, duty;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n, power_request, vminus_good, vplus_good, fault_clear;
  logic vminus_enable, vplus_pwm, lna_ready, fault;
  logic [1:0] fault_code;
  logic [2:0] state;
  int pass = 0, total = 0, order_err = 0;
  vec_t vq[$];
  always #5 clk = ~clk;
  lna_power_sequencer #(
    .RAMP_STEP_CYC(2), .NEG_TIMEOUT_CYC(20), .NEG_SETTLE_CYC(5),
    .POS_TIMEOUT_CYC(20), .NEG_HOLD_CYC(4)
  ) dut (
    .Clock100Mhz  (clk),
    .ResetN       (reset_n),
    .PowerRequest (power_request),
    .VminusGood   (vminus_good),
    .VplusGood    (vplus_good),
    .FaultClear   (fault_clear),
    .VminusEnable (vminus_enable),
    .VplusPwm     (vplus_pwm),
    .LnaReady     (lna_ready),
    .Fault        (fault),
    .FaultCode    (fault_code),
    .State        (state)
  );
  // drain PWM must never be high while gate bias is off
  always @(negedge clk) if (reset_n && vplus_pwm && !vminus_enable) order_err++;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask
  task automatic add(input string nm, input bit req, vm, vp, fclr, input int cyc, st, flt, code, ven, rdy, pwm, duty);
    vec_t v;
    v.nm = nm; v.req = req; v.vm = vm; v.vp = vp; v.fclr = fclr; v.cyc = cyc;
    v.st = st; v.flt = flt; v.code = code; v.ven = ven; v.rdy = rdy; v.pwm = pwm; v.duty = duty;
    vq.push_back(v);
  endtask
  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      power_request = vq[i].req;
      vminus_good = vq[i].vm;
      vplus_good = vq[i].vp;
      fault_clear = vq[i].fclr;
      repeat (vq[i].cyc) tick();
      chk({vq[i].nm, ".state"}, int'(state), vq[i].st);
      chk({vq[i].nm, ".fault"}, int'(fault), vq[i].flt);
      chk({vq[i].nm, ".code"}, int'(fault_code), vq[i].code);
      chk({vq[i].nm, ".ven"}, int'(vminus_enable), vq[i].ven);
      chk({vq[i].nm, ".ready"}, int'(lna_ready), vq[i].rdy);
      if (vq[i].pwm >= 0) chk({vq[i].nm, ".pwm"}, int'(vplus_pwm), vq[i].pwm);
      if (vq[i].duty >= 0) chk({vq[i].nm, ".duty"}, int'(dut.u_pwm.duty), vq[i].duty);
    end
  endtask
  task automatic wait_st(input int s, input int lim, input string nm);
    int n = 0;
    while (int'(state) != s && n < lim) begin tick(); n++; end
    chk(nm, int'(state), s);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, ".state"}, int'(state), 0);
    chk({nm, ".ven"}, int'(vminus_enable), 0);
    chk({nm, ".pwm"}, int'(vplus_pwm), 0);
    chk({nm, ".ready"}, int'(lna_ready), 0);
    chk({nm, ".fault"}, int'(fault), 0);
    chk({nm, ".code"}, int'(fault_code), 0);
    chk({nm, ".duty"}, int'(dut.u_pwm.duty), 0);
  endtask
  initial begin
    int n, prev, d, jumps, steps;
    //   name            req vm vp fc  cyc  st f  c  ven rdy pwm duty
    add("a_req",          1, 0, 0, 0,   1,  1, 0, 0, 1,  0,  0,   0);
    add("a_nw",           1, 0, 0, 0,   1,  1, 0, 0, 1,  0,  0,   0);
    add("a_vm_sync",      1, 1, 0, 0,   2,  1, 0, 0, 1,  0,  0,   0);
    add("a_settle",       1, 1, 0, 0,   1,  2, 0, 0, 1,  0,  0,   0);
    add("a_settle_end",   1, 1, 0, 0,   4,  2, 0, 0, 1,  0,  0,   0);
    add("a_ramp",         1, 1, 0, 0,   1,  3, 0, 0, 1,  0,  0,   0);
    add("a_duty255",      1, 1, 0, 0, 511,  3, 0, 0, 1,  0, -1, 255);
    add("a_duty256",      1, 1, 0, 0,   1,  3, 0, 0, 1,  0, -1, 256);
    add("a_pos_wait",     1, 1, 0, 0,   1,  4, 0, 0, 1,  0,  1, 256);
    add("a_vp_sync",      1, 1, 1, 0,   2,  4, 0, 0, 1,  0,  1, 256);
    add("a_on",           1, 1, 1, 0,   1,  5, 0, 0, 1,  1,  1, 256);
    add("b_drop",         0, 1, 1, 0,   1,  6, 0, 0, 1,  0,  1, 256);
    add("b_duty1",        0, 1, 1, 0, 511,  6, 0, 0, 1,  0, -1,   1);
    add("b_duty0",        0, 1, 1, 0,   1,  6, 0, 0, 1,  0, -1,   0);
    add("b_neg_down",     0, 1, 1, 0,   1,  7, 0, 0, 1,  0,  0,   0);
    add("b_hold",         0, 1, 1, 0,   3,  7, 0, 0, 1,  0,  0,   0);
    add("b_off",          0, 0, 0, 0,   1,  0, 0, 0, 0,  0,  0,   0);
    add("c_req",          1, 0, 0, 0,   1,  1, 0, 0, 1,  0,  0,   0);
    add("c_nw_wait",      1, 0, 0, 0,  19,  1, 0, 0, 1,  0,  0,   0);
    add("c_timeout",      1, 0, 0, 0,   1,  0, 1, 1, 1,  0,  0,   0);
    add("c_clr_early",    0, 0, 0, 1,   1,  0, 1, 1, 1,  0,  0,   0);
    add("c_hold_off",     0, 0, 0, 0,   3,  0, 1, 1, 0,  0,  0,   0);
    add("c_clr_req",      1, 0, 0, 1,   2,  0, 1, 1, 0,  0,  0,   0);
    add("c_clr_ok",       0, 0, 0, 1,   1,  0, 0, 0, 0,  0,  0,   0);
    add("d_req",          1, 1, 1, 0,   1,  1, 0, 0, 1,  0,  0,   0);
    add("d_settle",       1, 1, 1, 0,   2,  2, 0, 0, 1,  0,  0,   0);
    add("d_pos_wait",     1, 1, 1, 0, 518,  4, 0, 0, 1,  0,  1, 256);
    add("d_on",           1, 1, 1, 0,   1,  5, 0, 0, 1,  1,  1, 256);
    add("d_loss_sync",    1, 0, 0, 0,   2,  5, 0, 0, 1,  1,  1, 256);
    add("d_loss",         1, 0, 0, 0,   1,  0, 1, 3, 1,  0,  0,   0);
    add("d_hold",         0, 0, 0, 0,   4,  0, 1, 3, 0,  0,  0,   0);
    add("d_clear",        0, 0, 0, 1,   1,  0, 0, 0, 0,  0,  0,   0);
    reset_n = 1'b0; power_request = 1'b0; vminus_good = 1'b0; vplus_good = 1'b0; fault_clear = 1'b0;
    repeat (2) tick();
    chk_reset("reset");
    reset_n = 1'b1;
    run(0, vq.size() - 1);
    // abort the ramp at duty 100 and watch it walk back down one step at a time
    fault_clear = 1'b0; power_request = 1'b1; vminus_good = 1'b1; vplus_good = 1'b0;
    wait_st(3, 40, "e_ramp");
    n = 0;
    while (int'(dut.u_pwm.duty) != 100 && n < 400) begin tick(); n++; end
    chk("e_duty100", int'(dut.u_pwm.duty), 100);
    power_request = 1'b0;
    tick();
    chk("e_pos_down", int'(state), 6);
    chk("e_no_jump_entry", int'(dut.u_pwm.duty), 100);
    prev = 100; jumps = 0; steps = 0; n = 0;
    while (int'(state) != 7 && n < 400) begin
      tick(); n++;
      d = int'(dut.u_pwm.duty);
      if (d > prev || prev - d > 1) jumps++;
      if (d != prev) steps++;
      prev = d;
    end
    chk("e_neg_down", int'(state), 7);
    chk("e_jumps", jumps, 0);
    chk("e_steps", steps, 100);
    chk("e_duty_zero", int'(dut.u_pwm.duty), 0);
    power_request = 1'b1;
    repeat (3) tick();
    chk("e_reassert_ignored", int'(state), 7);
    tick();
    chk("e_off", int'(state), 0);
    tick();
    chk("e_restart", int'(state), 1);
    // reset while ON, then the power-up must replay exactly
    vplus_good = 1'b1;
    wait_st(5, 700, "f_on");
    reset_n = 1'b0; power_request = 1'b0; vminus_good = 1'b0; vplus_good = 1'b0;
    tick();
    chk_reset("f_reset");
    reset_n = 1'b1;
    run(0, 10);
    chk("order_vminus_first", order_err, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
